// File: rtl/keypad_if.sv
// keypad_if - bundle between keypad_scanner and its neighbours.
//
// Signals
//   rows_n    keypad rows, active-low, pulled up externally; bit 0 = top row
//   cols_n    keypad column drive, active-low, exactly one bit low; bit 0 = left column
//   key_out   [7:4] row one-hot (bit 7 = row 0), [3:0] column one-hot (bit 0 = col 0)
//   key_valid one-cycle strobe in the cycle key_out takes a newly accepted press
//   key_held  high while the accepted key is still pressed
//
// Handshake: key_valid is a pure strobe with no ready. The consumer must take
// key_out in the cycle key_valid is high; key_out keeps that value until the
// next strobe, so late readers still see the last accepted key.
//
// Modports
//   master - the scanner: samples rows_n, drives everything else
//   slave  - the keypad/consumer side
interface keypad_if;
  logic [3:0] rows_n;
  logic [3:0] cols_n;
  logic [7:0] key_out;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  rows_n,
    output cols_n,
    output key_out,
    output key_valid,
    output key_held
  );

  modport slave (
    output rows_n,
    input  cols_n,
    input  key_out,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner - 4x4 matrix keypad scanner with synchronizer and debounce.
//
// Drives one column low at a time, waits SCAN_CYCLES for the rows to settle
// through the 2-flop synchronizer, and on a low row debounces that single
// row/column crossing before reporting it as a one-hot {row, col} code with a
// one-cycle key_valid strobe. While the key is held the column stays driven
// and every other key is ignored; a debounced release resumes scanning at the
// next column.
//
// Ports
//   clk       system clock, rising edge
//   reset     synchronous, active-high
//   bus       keypad_if.master (rows_n in; cols_n, key_out, key_valid, key_held out)
//   dbg_state current FSM state: 0 SCAN, 1 PRESS_DB, 2 HELD, 3 REL_DB
module keypad_scanner #(
  parameter logic [15:0] SCAN_CYCLES     = 16'd50000,
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd200000
) (
  input  logic           clk,
  input  logic           reset,
  keypad_if.master       bus,
  output logic [1:0]     dbg_state
);

  localparam int SCAN_W = (SCAN_CYCLES > 16'd1) ? $clog2(int'(SCAN_CYCLES)) : 1;
  localparam int DB_W   = $clog2(int'(DEBOUNCE_CYCLES) + 1);

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 16'd1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 20'd1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_t;

  state_t            state, state_d;
  logic [1:0]        col_idx, col_d;
  logic [1:0]        row_idx, row_d;
  logic [SCAN_W-1:0] scan_cnt, scan_cnt_d;
  logic [DB_W-1:0]   db_cnt, db_cnt_d;
  logic [3:0]        cols_q, cols_d;
  logic [7:0]        key_q, key_d;
  logic              valid_q, valid_d;
  logic              held_q, held_d;
  logic [3:0]        rows_meta, rows_s;
  logic [1:0]        low_row;

  // Two-flop synchronizer; idle (all rows released) is all ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      rows_meta <= 4'b1111;
      rows_s    <= 4'b1111;
    end else begin
      rows_meta <= bus.rows_n;
      rows_s    <= rows_meta;
    end
  end

  // Lowest-index low row wins when several rows are low in one column.
  always_comb begin
    low_row = 2'd3;
    if (!rows_s[0])      low_row = 2'd0;
    else if (!rows_s[1]) low_row = 2'd1;
    else if (!rows_s[2]) low_row = 2'd2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= SCAN;
      col_idx  <= 2'd0;
      row_idx  <= 2'd0;
      scan_cnt <= '0;
      db_cnt   <= '0;
      cols_q   <= 4'b1110;
      key_q    <= 8'h00;
      valid_q  <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      state    <= state_d;
      col_idx  <= col_d;
      row_idx  <= row_d;
      scan_cnt <= scan_cnt_d;
      db_cnt   <= db_cnt_d;
      cols_q   <= cols_d;
      key_q    <= key_d;
      valid_q  <= valid_d;
      held_q   <= held_d;
    end
  end

  always_comb begin
    state_d    = state;
    col_d      = col_idx;
    row_d      = row_idx;
    scan_cnt_d = scan_cnt;
    db_cnt_d   = db_cnt;
    key_d      = key_q;
    valid_d    = 1'b0;

    case (state)
      SCAN: begin
        if (scan_cnt == SCAN_LAST) begin
          scan_cnt_d = '0;
          if (rows_s != 4'b1111) begin
            // Column stays driven so the debounce watches the same crossing.
            row_d    = low_row;
            db_cnt_d = '0;
            state_d  = PRESS_DB;
          end else begin
            col_d = 2'(col_idx + 2'd1);
          end
        end else begin
          scan_cnt_d = scan_cnt + 1'b1;
        end
      end

      PRESS_DB: begin
        if (rows_s[row_idx]) begin
          state_d    = SCAN;
          col_d      = 2'(col_idx + 2'd1);
          scan_cnt_d = '0;
        end else if (db_cnt == DB_LAST) begin
          state_d  = HELD;
          key_d    = {4'b1000 >> row_idx, 4'b0001 << col_idx};
          valid_d  = 1'b1;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt + 1'b1;
        end
      end

      HELD: begin
        if (rows_s[row_idx]) begin
          db_cnt_d = '0;
          state_d  = REL_DB;
        end
      end

      REL_DB: begin
        if (!rows_s[row_idx]) begin
          // Release bounce: back to HELD, no new strobe.
          state_d = HELD;
        end else if (db_cnt == DB_LAST) begin
          state_d    = SCAN;
          col_d      = 2'(col_idx + 2'd1);
          scan_cnt_d = '0;
          db_cnt_d   = '0;
        end else begin
          db_cnt_d = db_cnt + 1'b1;
        end
      end

      default: state_d = SCAN;
    endcase

    held_d = (state_d == HELD) || (state_d == REL_DB);
    cols_d = ~(4'b0001 << col_d);
  end

  assign bus.cols_n    = cols_q;
  assign bus.key_out   = key_q;
  assign bus.key_valid = valid_q;
  assign bus.key_held  = held_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;
  localparam logic [15:0] SC = 16'd4;
  localparam logic [19:0] DC = 20'd8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dbg_state;
  logic [15:0] pressed = '0;   // bit r*4+c = key at row r, column c
  logic [3:0]  rows_model;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;
  logic [7:0] got_q[$];

  keypad_if bus();

  keypad_scanner #(.SCAN_CYCLES(SC), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .bus(bus), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Keypad model: a row is pulled low by any pressed key in the driven column.
  always_comb begin
    rows_model = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !bus.cols_n[c]) rows_model[r] = 1'b0;
  end
  assign bus.rows_n = rows_model;

  // Pulse recorder: every high key_valid cycle counts as a separate pulse.
  always @(negedge clk) begin
    if (bus.key_valid === 1'b1) begin
      pulse_cnt++;
      got_q.push_back(bus.key_out);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_pulse(input int start, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (pulse_cnt > start) begin ok = 1'b1; break; end
      tick(1);
    end
    if (pulse_cnt > start) ok = 1'b1;
  endtask

  task automatic pop_code(output logic [7:0] code);
    if (got_q.size() > 0) code = got_q.pop_front();
    else code = 8'hxx;
  endtask

  // Align to the first cycle of column 0 so scan order is known.
  task automatic wait_col0(output bit ok);
    bit seen3 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.cols_n == 4'b0111) seen3 = 1'b1;
      else if (seen3 && bus.cols_n == 4'b1110) begin ok = 1'b1; break; end
      tick(1);
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.key_held === 1'b0 && dbg_state == 2'd0) begin ok = 1'b1; break; end
      tick(1);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    logic [3:0] pat [4];
    pat[0] = 4'b1110; pat[1] = 4'b1101; pat[2] = 4'b1011; pat[3] = 4'b0111;
    reset = 1'b1;
    pressed = '0;
    tick(2);
    reset = 1'b0;
    n_checks++; if (bus.key_out !== 8'h00) begin n_fail++; $display("FAIL reset_key_out: got %h expected 00", bus.key_out); end
    n_checks++; if (bus.key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_key_valid: got %b expected 0", bus.key_valid); end
    n_checks++; if (bus.key_held !== 1'b0) begin n_fail++; $display("FAIL reset_key_held: got %b expected 0", bus.key_held); end
    n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) tick(1);
      n_checks++;
      if (bus.cols_n !== pat[(i/4)%4]) begin
        n_fail++; $display("FAIL scan_cols step %0d: got %b expected %b", i, bus.cols_n, pat[(i/4)%4]);
      end
    end
  endtask

  task automatic test_press_hold;
    int start;
    bit ok;
    logic [7:0] code;
    start = pulse_cnt;
    pressed[5] = 1'b1;   // key 5: row 1, col 1
    wait_pulse(start, 100, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL press5_timeout: got no pulse expected 1"); end
    pop_code(code);
    n_checks++; if (code !== 8'b0100_0010) begin n_fail++; $display("FAIL press5_code: got %b expected 01000010", code); end
    tick(30);
    n_checks++; if (pulse_cnt !== start + 1) begin n_fail++; $display("FAIL press5_pulses: got %0d expected %0d", pulse_cnt - start, 1); end
    n_checks++; if (bus.key_held !== 1'b1) begin n_fail++; $display("FAIL press5_held: got %b expected 1", bus.key_held); end
    n_checks++; if (bus.cols_n !== 4'b1101) begin n_fail++; $display("FAIL press5_col: got %b expected 1101", bus.cols_n); end
    pressed[5] = 1'b0;
    tick(10);
    n_checks++; if (bus.key_held !== 1'b1) begin n_fail++; $display("FAIL rel5_held_late: got %b expected 1", bus.key_held); end
    tick(1);
    n_checks++; if (bus.key_held !== 1'b0) begin n_fail++; $display("FAIL rel5_held_end: got %b expected 0", bus.key_held); end
    n_checks++; if (bus.cols_n !== 4'b1011) begin n_fail++; $display("FAIL rel5_resume_col: got %b expected 1011", bus.cols_n); end
    n_checks++; if (bus.key_out !== 8'b0100_0010) begin n_fail++; $display("FAIL rel5_key_kept: got %b expected 01000010", bus.key_out); end
  endtask

  task automatic test_bounce;
    int start;
    bit ok;
    logic [7:0] code;
    start = pulse_cnt;
    for (int k = 0; k < 10; k++) begin
      pressed[12] = (k % 2 == 0);   // key A: row 3, col 0
      tick(3);
    end
    n_checks++; if (pulse_cnt !== start) begin n_fail++; $display("FAIL bounceA_no_pulse: got %0d expected 0", pulse_cnt - start); end
    pressed[12] = 1'b1;
    wait_pulse(start, 200, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bounceA_timeout: got no pulse expected 1"); end
    pop_code(code);
    n_checks++; if (code !== 8'b0001_0001) begin n_fail++; $display("FAIL bounceA_code: got %b expected 00010001", code); end
    tick(20);
    n_checks++; if (pulse_cnt !== start + 1) begin n_fail++; $display("FAIL bounceA_pulses: got %0d expected 1", pulse_cnt - start); end
    pressed = '0;
    wait_idle(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bounceA_idle: got busy expected idle"); end
  endtask

  task automatic test_simultaneous;
    int start;
    bit ok;
    logic [7:0] code;
    start = pulse_cnt;
    wait_col0(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL simul_align: got no col0 expected col0"); end
    pressed[0] = 1'b1;   // key 1: row 0, col 0
    pressed[3] = 1'b1;   // key C: row 0, col 3
    wait_pulse(start, 100, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL simul_timeout: got no pulse expected 1"); end
    pop_code(code);
    n_checks++; if (code !== 8'b1000_0001) begin n_fail++; $display("FAIL simul_code1: got %b expected 10000001", code); end
    tick(40);
    n_checks++; if (pulse_cnt !== start + 1) begin n_fail++; $display("FAIL simul_c_ignored: got %0d expected 1", pulse_cnt - start); end
    pressed[0] = 1'b0;
    wait_pulse(start + 1, 200, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL simulC_timeout: got no pulse expected 1"); end
    pop_code(code);
    n_checks++; if (code !== 8'b1000_1000) begin n_fail++; $display("FAIL simul_codeC: got %b expected 10001000", code); end
    pressed = '0;
    wait_idle(ok);
    n_checks++; if (pulse_cnt !== start + 2) begin n_fail++; $display("FAIL simul_pulses: got %0d expected 2", pulse_cnt - start); end
  endtask

  task automatic test_release_glitch;
    int start;
    bit ok;
    bit held_ok;
    logic [7:0] code;
    start = pulse_cnt;
    pressed[15] = 1'b1;   // key F: row 3, col 3
    wait_pulse(start, 100, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL glitchF_timeout: got no pulse expected 1"); end
    pop_code(code);
    n_checks++; if (code !== 8'b0001_1000) begin n_fail++; $display("FAIL glitchF_code: got %b expected 00011000", code); end
    tick(20);
    pressed[15] = 1'b0;
    held_ok = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      tick(1);
      if (i == 5) pressed[15] = 1'b1;
      if (i == 7) pressed[15] = 1'b0;
      if (bus.key_held !== 1'b1) held_ok = 1'b0;
    end
    n_checks++; if (held_ok !== 1'b1) begin n_fail++; $display("FAIL glitchF_held: got dropped expected held through 17 cycles"); end
    tick(1);
    n_checks++; if (bus.key_held !== 1'b0) begin n_fail++; $display("FAIL glitchF_release: got %b expected 0", bus.key_held); end
    tick(10);
    n_checks++; if (pulse_cnt !== start + 1) begin n_fail++; $display("FAIL glitchF_pulses: got %0d expected 1", pulse_cnt - start); end
  endtask

  task automatic test_reset_mid;
    int start;
    bit ok;
    logic [7:0] code;
    start = pulse_cnt;
    pressed[10] = 1'b1;   // key 9: row 2, col 2
    wait_pulse(start, 100, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL mid9_timeout: got no pulse expected 1"); end
    pop_code(code);
    n_checks++; if (code !== 8'b0010_0100) begin n_fail++; $display("FAIL mid9_code: got %b expected 00100100", code); end
    tick(5);
    reset = 1'b1;
    tick(1);
    n_checks++; if (bus.key_out !== 8'h00) begin n_fail++; $display("FAIL mid_reset_key_out: got %h expected 00", bus.key_out); end
    n_checks++; if (bus.key_held !== 1'b0) begin n_fail++; $display("FAIL mid_reset_held: got %b expected 0", bus.key_held); end
    n_checks++; if (bus.cols_n !== 4'b1110) begin n_fail++; $display("FAIL mid_reset_cols: got %b expected 1110", bus.cols_n); end
    n_checks++; if (bus.key_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b expected 0", bus.key_valid); end
    reset = 1'b0;
    start = pulse_cnt;
    wait_pulse(start, 200, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL mid9_redetect: got no pulse expected 1"); end
    pop_code(code);
    n_checks++; if (code !== 8'b0010_0100) begin n_fail++; $display("FAIL mid9_code2: got %b expected 00100100", code); end
    tick(20);
    n_checks++; if (pulse_cnt !== start + 1) begin n_fail++; $display("FAIL mid9_pulses: got %0d expected 1", pulse_cnt - start); end
    pressed = '0;
    wait_idle(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL mid9_idle: got busy expected idle"); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_press_hold();
    test_bounce();
    test_simultaneous();
    test_release_glitch();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Drives the 4x4 matrix keypad columns one at a time and samples the rows. It synchronizes and debounces the row inputs and detects a single key press. It emits the one-hot {row, col} code plus a one-cycle key_valid strobe, which feed keypadLUT directly. It sits between the keypad pins and keypadLUT in the lab03 top level.

Parameters:
SCAN_CYCLES, 16'd50000, clk cycles each column is driven before its rows are sampled; minimum 3, to cover the 2-flop synchronizer plus settling.
DEBOUNCE_CYCLES, 20'd200000, consecutive stable cycles required to accept a press or a release; minimum 1.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
reset  input  1  synchronous, active-high reset.
rows_n  input  4  keypad rows, active-low, externally pulled up; bit 0 is the top row (1 2 3 C), bit 3 is the bottom row (A 0 B F).
cols_n  output  4  keypad column drive, active-low, exactly one bit low at all times; bit 0 is the left column (1 4 7 A), bit 3 is the right column (C D E F).
key_out  output  8  [7:4] row one-hot, bit 7 = row 0 ... bit 4 = row 3; [3:0] column one-hot, bit 0 = col 0 ... bit 3 = col 3. Example: 5 = 8'b0100_0010, A = 8'b0001_0001.
key_valid  output  1  one-cycle pulse in the cycle key_out updates to a new press.
key_held  output  1  high while the accepted key remains pressed (HELD and REL_DB states).

Behaviour:
- Reset values: state SCAN, col_idx = 0, cols_n = 4'b1110, key_out = 8'h00, key_valid = 0, key_held = 0, both counters = 0, synchronizer flops = 4'b1111.
- rows_n passes through a 2-flop synchronizer to produce rows_s; all decisions use rows_s.
- cols_n = ~(4'b0001 << col_idx). It is registered and changes only on state transitions described below.
- SCAN:
  - The dwell counter runs 0..SCAN_CYCLES-1.
  - On the last dwell cycle, if any rows_s bit is 0: capture row_idx as the lowest-index low row, clear the counter, go to PRESS_DB. col_idx holds.
  - Otherwise advance col_idx (3 wraps to 0) and restart the dwell.
- PRESS_DB:
  - Each cycle rows_s[row_idx] is checked. If it is 1, return to SCAN, advance col_idx, and do not pulse key_valid.
  - After DEBOUNCE_CYCLES consecutive low cycles: register key_out = {1<<(3-row_idx), 1<<col_idx}, assert key_valid for exactly that one cycle, go to HELD.
- HELD:
  - key_held = 1 and the column stays driven.
  - Other rows, and other keys in other columns, are ignored.
  - When rows_s[row_idx] = 1, clear the counter and go to REL_DB.
- REL_DB:
  - key_held = 1.
  - If rows_s[row_idx] = 0 at any point, return to HELD; this is a bounce and produces no key_valid.
  - After DEBOUNCE_CYCLES consecutive high cycles, go to SCAN, advance col_idx, and set key_held = 0.
- key_out holds its last accepted value until the next accepted press. It is never cleared except by reset.
- Press latency: with the key already stable, key_valid follows the column's sample point by DEBOUNCE_CYCLES + 1 cycles.
- Simultaneous keys:
  - The first column reached in scan order wins; within a column, the lowest row index wins.
  - Exactly one key is reported per press/release cycle.
- Reset mid-operation: in any state, the next edge restores all reset values and produces no key_valid. A key still held after reset is detected again as a fresh press.
- Counters are sized to hold SCAN_CYCLES-1 and DEBOUNCE_CYCLES, and must not wrap.

Test Plan:
The bench keypad model drives rows_n[r] = AND over c of ~(pressed[r][c] & ~cols_n[c]). Use SCAN_CYCLES=4 and DEBOUNCE_CYCLES=8.
1. Reset held 2 cycles, no keys pressed -> key_out = 8'h00, key_valid = 0, key_held = 0; cols_n steps 1110, 1101, 1011, 0111, 1110, with each value held 4 cycles.
2. Press 5 and hold it stable -> exactly one key_valid pulse with key_out = 8'b0100_0010. key_held = 1 until 8 cycles after release plus synchronizer delay, after which scanning resumes at col 2.
3. Press A, toggling every 3 cycles for 30 cycles, then stable -> no pulse during the bounce, then one pulse with key_out = 8'b0001_0001.
4. Press 1 and C together -> one pulse with key_out = 8'b1000_0001. C produces no pulse while 1 is held, and C is reported as 8'b1000_1000 after 1 is released.
5. Hold F, release it, then glitch low 5 cycles after release -> no second pulse. key_held stays 1 until the release has been stable 8 cycles.
6. Assert reset while in HELD with 9 still pressed -> the next cycle shows key_out = 8'h00, key_held = 0, cols_n = 1110. After reset is released, one new pulse with key_out = 8'b0010_0100.
